systemx_sweeper: RTL and testbench



---
 rtl/systemx_sweeper_if.sv | 35 +++
 rtl/systemx_sweeper.sv | 154 +++++++++++++++
 tb/tb_systemx_sweeper.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/systemx_sweeper_if.sv
// Signal bundle between systemx_sweeper and whatever drives it and hosts systemx.
//   master: drives START, GOLDEN and Y (systemx output); observes vector and results.
//   slave : the sweeper itself.
// Signals:
//   START      begin a sweep (taken only when BUSY=0)
//   GOLDEN     expected Y per vector, bit i = vector i
//   Y          systemx output under test
//   A,B,C,D    applied vector, A = MSB
//   BUSY/DONE  sweep in progress / one-cycle end pulse
//   PASS, ERR_CNT, FIRST_FAIL, FAIL_VALID  results of the last sweep
interface systemx_sweeper_if;
  logic        START;
  logic [15:0] GOLDEN;
  logic        Y;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        BUSY;
  logic        DONE;
  logic        PASS;
  logic [4:0]  ERR_CNT;
  logic [3:0]  FIRST_FAIL;
  logic        FAIL_VALID;

  modport master (
    output START, GOLDEN, Y,
    input  A, B, C, D, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_VALID
  );

  modport slave (
    input  START, GOLDEN, Y,
    output A, B, C, D, BUSY, DONE, PASS, ERR_CNT, FIRST_FAIL, FAIL_VALID
  );
endinterface

// File: rtl/systemx_sweeper.sv
// Exhaustive on-chip sweep of the 4-input combinational systemx block.
// Steps {A,B,C,D} through vectors 0..15, holds each for SETTLE_CYCLES cycles, then samples Y
// for one cycle and compares it with the GOLDEN table latched at START. Reports PASS,
// ERR_CNT, FIRST_FAIL/FAIL_VALID and pulses DONE at the end. All outputs are registered.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  systemx_sweeper_if.slave (START, GOLDEN, Y in; vector and results out)
// Build option:
//   SYSTEMX_STOP_ON_FAIL_EN  when defined, the first mismatch ends the sweep immediately.
module systemx_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input logic              CLK,
  input logic              RST,
  systemx_sweeper_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StFinish} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      golden_q, golden_d;
  logic [4:0]       err_cnt_q, err_cnt_d;
  logic [3:0]       first_fail_q, first_fail_d;
  logic             fail_valid_q, fail_valid_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       abcd_q, abcd_d;
  logic             mismatch;
  logic             stop;

  assign mismatch = (bus.Y != golden_q[v_q]);

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    cnt_d        = cnt_q;
    golden_d     = golden_q;
    err_cnt_d    = err_cnt_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abcd_d       = abcd_q;
    stop         = 1'b0;

    unique case (state_q)
      StIdle: begin
        abcd_d = 4'd0;
        if (bus.START) begin
          golden_d     = bus.GOLDEN;
          v_d          = 4'd0;
          cnt_d        = '0;
          err_cnt_d    = 5'd0;
          first_fail_d = 4'd0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = StSettle;
        end
      end

      StSettle: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StSample: begin
        if (mismatch) begin
          // At most 16 increments per sweep, so 5 bits never wrap.
          err_cnt_d = err_cnt_q + 5'd1;
          if (!fail_valid_q) begin
            first_fail_d = v_q;
            fail_valid_d = 1'b1;
          end
        end
`ifdef SYSTEMX_STOP_ON_FAIL_EN
        stop = (v_q == 4'd15) || mismatch;
`else
        stop = (v_q == 4'd15);
`endif
        if (stop) begin
          // DONE and PASS are registered, so they are set on entry to FINISH.
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 5'd0);
          state_d = StFinish;
        end else begin
          v_d     = v_q + 4'd1;
          abcd_d  = v_q + 4'd1;
          state_d = StSettle;
        end
      end

      StFinish: begin
        busy_d  = 1'b0;
        abcd_d  = 4'd0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      v_q          <= 4'd0;
      cnt_q        <= '0;
      golden_q     <= 16'd0;
      err_cnt_q    <= 5'd0;
      first_fail_q <= 4'd0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abcd_q       <= 4'd0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      cnt_q        <= cnt_d;
      golden_q     <= golden_d;
      err_cnt_q    <= err_cnt_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abcd_q       <= abcd_d;
    end
  end

  assign bus.A          = abcd_q[3];
  assign bus.B          = abcd_q[2];
  assign bus.C          = abcd_q[1];
  assign bus.D          = abcd_q[0];
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;
  assign bus.PASS       = pass_q;
  assign bus.ERR_CNT    = err_cnt_q;
  assign bus.FIRST_FAIL = first_fail_q;
  assign bus.FAIL_VALID = fail_valid_q;

endmodule

// File: tb/tb_systemx_sweeper.sv
// Directed bench for systemx_sweeper with a behavioural systemx: Y = (A & B) | (C ^ D).
// Its truth table (bit i = vector i, A = MSB) is 16'hF666.
module tb_systemx_sweeper;

  localparam int unsigned S = 2;
  localparam int DoneCyc = 16 * (S + 1) + 1;
  localparam int Win = DoneCyc + 11;
  localparam logic [15:0] Good = 16'hF666;

  logic CLK = 1'b0;
  logic RST;

  systemx_sweeper_if bus ();

  systemx_sweeper #(
    .SETTLE_CYCLES(S),
    .CNT_W        (4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  assign bus.Y = (bus.A & bus.B) | (bus.C ^ bus.D);

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Starts a sweep and watches a fixed window. Cycle 1 is the first SETTLE cycle.
  task automatic run_sweep(input logic [15:0] g, input bit disturb,
                           output int done_cyc, output int n_done, output int trace_err);
    int exp_v;
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.GOLDEN = g;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    done_cyc  = -1;
    n_done    = 0;
    trace_err = 0;
    for (int k = 1; k <= Win; k++) begin
      @(negedge CLK);
      if (k < DoneCyc) exp_v = (k - 1) / (S + 1);
      else if (k == DoneCyc) exp_v = 15;
      else exp_v = 0;
      if (int'({bus.A, bus.B, bus.C, bus.D}) != exp_v) trace_err++;
      if (bus.BUSY != (k <= DoneCyc)) trace_err++;
      if (bus.DONE) begin
        n_done++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (disturb) begin
        bus.START = (k == 10 || k == 30);
        if (k == 7 * (S + 1) + 1) bus.GOLDEN = ~g;
      end
    end
    bus.START = 1'b0;
  endtask

  typedef struct {
    logic [15:0] golden;
    bit          disturb;
    int          err;
    int          first;
    int          valid;
    int          pass;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int dc, nd, te;
    int d1, d2, b_gap, b_re;

    tbl[0] = '{Good,     1'b0, 0,  0,  0, 1};
    tbl[1] = '{16'hF646, 1'b0, 1,  5,  1, 0};
    tbl[2] = '{16'h0999, 1'b0, 16, 0,  1, 0};
    tbl[3] = '{Good,     1'b0, 0,  0,  0, 1};
    tbl[4] = '{16'h7667, 1'b0, 2,  0,  1, 0};
    tbl[5] = '{16'h7666, 1'b0, 1,  15, 1, 0};
    tbl[6] = '{16'hF646, 1'b1, 1,  5,  1, 0};

    RST        = 1'b1;
    bus.START  = 1'b0;
    bus.GOLDEN = 16'd0;
    #1;
    check("reset_outputs", int'({bus.A, bus.B, bus.C, bus.D, bus.BUSY, bus.DONE, bus.PASS,
                                 bus.ERR_CNT, bus.FIRST_FAIL, bus.FAIL_VALID}), 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].golden, tbl[i].disturb, dc, nd, te);
      check($sformatf("row%0d_done_cycle", i), dc, DoneCyc);
      check($sformatf("row%0d_done_pulses", i), nd, 1);
      check($sformatf("row%0d_trace_errs", i), te, 0);
      check($sformatf("row%0d_err_cnt", i), int'(bus.ERR_CNT), tbl[i].err);
      check($sformatf("row%0d_first_fail", i), int'(bus.FIRST_FAIL), tbl[i].first);
      check($sformatf("row%0d_fail_valid", i), int'(bus.FAIL_VALID), tbl[i].valid);
      check($sformatf("row%0d_pass", i), int'(bus.PASS), tbl[i].pass);
    end

    // Reset while vector 9 is applied; everything must clear without a clock edge.
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.GOLDEN = 16'h0999;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    repeat (9 * (S + 1) + 1) @(negedge CLK);
    check("pre_rst_vector", int'({bus.A, bus.B, bus.C, bus.D}), 9);
    check("pre_rst_err_cnt", int'(bus.ERR_CNT), 9);
    #1 RST = 1'b1;
    #1;
    check("rst_async_outputs", int'({bus.A, bus.B, bus.C, bus.D, bus.BUSY, bus.DONE, bus.PASS,
                                     bus.ERR_CNT, bus.FIRST_FAIL, bus.FAIL_VALID}), 0);
    @(negedge CLK);
    RST = 1'b0;
    run_sweep(Good, 1'b0, dc, nd, te);
    check("post_rst_done_cycle", dc, DoneCyc);
    check("post_rst_trace_errs", te, 0);
    check("post_rst_pass", int'(bus.PASS), 1);
    check("post_rst_err_cnt", int'(bus.ERR_CNT), 0);

    // START held high: the next sweep begins on the first IDLE cycle after FINISH.
    @(negedge CLK);
    bus.START  = 1'b1;
    bus.GOLDEN = Good;
    @(posedge CLK);
    d1    = -1;
    d2    = -1;
    b_gap = -1;
    b_re  = -1;
    for (int k = 1; k <= 2 * DoneCyc + 5; k++) begin
      @(negedge CLK);
      if (bus.DONE) begin
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == DoneCyc + 1) b_gap = int'(bus.BUSY);
      if (k == DoneCyc + 2) b_re = int'(bus.BUSY);
      if (k == 2 * DoneCyc) bus.START = 1'b0;
    end
    bus.START = 1'b0;
    check("held_first_done", d1, DoneCyc);
    check("held_idle_busy", b_gap, 0);
    check("held_restart_busy", b_re, 1);
    check("held_second_done", d2, 2 * DoneCyc + 1);
    check("held_pass", int'(bus.PASS), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
